ysyx_041461_mem: RTL

Memory-access pipeline stage of the ysyx_041461 core. It sits between EXE and WB and is the receiving end of the EXE valid/ready/trap interface: it takes the EXE result with `MEM_ready` ↔ `EXE_MEM_ready` and reports its held trap on `MEM_trap` ↔ `EXE_MEM_trap`. It runs loads and stores as a multi-cycle request/response transaction on the data-memory port and holds one result for WB.

---
 rtl/ysyx_041461_mem_pkg.sv | 49 ++++
 rtl/ysyx_041461_mem_if.sv | 21 ++
 rtl/ysyx_041461_mem_align.sv | 54 +++++
 rtl/ysyx_041461_mem.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ysyx_041461_mem_pkg.sv
// Shared encodings for the ysyx_041461 MEM stage: operation codes, trap codes,
// FSM states and small decode helpers used by the stage and its alignment unit.
package ysyx_041461_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LD  = 4'd4,
    MEM_LBU = 4'd5,
    MEM_LHU = 4'd6,
    MEM_LWU = 4'd7,
    MEM_SB  = 4'd8,
    MEM_SH  = 4'd9,
    MEM_SW  = 4'd10,
    MEM_SD  = 4'd11
  } mem_ctrl_e;

  localparam logic [3:0] TRAP_NOP            = 4'hF;
  localparam logic [3:0] TRAP_LOAD_MISALIGN  = 4'h4;
  localparam logic [3:0] TRAP_STORE_MISALIGN = 4'h6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } mem_state_e;

  function automatic logic is_load(input logic [3:0] ctrl);
    return (ctrl >= MEM_LB) && (ctrl <= MEM_LWU);
  endfunction

  function automatic logic is_store(input logic [3:0] ctrl);
    return (ctrl >= MEM_SB) && (ctrl <= MEM_SD);
  endfunction

  // log2 of the access size in bytes (0=byte .. 3=doubleword)
  function automatic logic [1:0] acc_size(input logic [3:0] ctrl);
    case (ctrl)
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      MEM_LW, MEM_LWU, MEM_SW: return 2'd2;
      MEM_LD, MEM_SD:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_041461_mem_if.sv
// Data-memory request/response port of the MEM stage; the stage is the master.
interface ysyx_041461_mem_if;
  logic        MEM_req_valid;
  logic        MEM_req_ready;
  logic [63:0] MEM_req_addr;
  logic        MEM_req_wen;
  logic [63:0] MEM_req_wdata;
  logic [7:0]  MEM_req_wmask;
  logic        MEM_resp_valid;
  logic [63:0] MEM_resp_rdata;

  modport master (
    output MEM_req_valid, MEM_req_addr, MEM_req_wen, MEM_req_wdata, MEM_req_wmask,
    input  MEM_req_ready, MEM_resp_valid, MEM_resp_rdata
  );

  modport slave (
    input  MEM_req_valid, MEM_req_addr, MEM_req_wen, MEM_req_wdata, MEM_req_wmask,
    output MEM_req_ready, MEM_resp_valid, MEM_resp_rdata
  );
endinterface

// File: rtl/ysyx_041461_mem_align.sv
// Byte-lane alignment for the MEM stage: misalignment detection, store lane
// placement and load extraction with sign/zero extension. Purely combinational.
module ysyx_041461_mem_align
  import ysyx_041461_mem_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [2:0]  off,
  input  logic [63:0] rs2,
  input  logic [63:0] rdata,
  output logic        misalign,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic [63:0] load_val
);

  logic [1:0]  sz;
  logic [5:0]  shamt;
  logic [63:0] rep;
  logic [7:0]  base_mask;
  logic [63:0] shifted;

  assign sz      = acc_size(ctrl);
  assign shamt   = {off, 3'b000};
  assign shifted = rdata >> shamt;

  // NOTE: every output of this block gets a default first, so no path can leave a latch.
  always_comb begin
    misalign  = 1'b0;
    rep       = rs2;
    base_mask = 8'hFF;
    case (sz)
      2'd0: begin rep = {8{rs2[7:0]}};  base_mask = 8'h01; end
      2'd1: begin rep = {4{rs2[15:0]}}; base_mask = 8'h03; misalign = off[0];          end
      2'd2: begin rep = {2{rs2[31:0]}}; base_mask = 8'h0F; misalign = (off[1:0] != 2'd0); end
      default: misalign = (off != 3'd0);
    endcase
    if (!(is_load(ctrl) || is_store(ctrl))) misalign = 1'b0;

    wmask = is_store(ctrl) ? (base_mask << off) : 8'h00;
    wdata = is_store(ctrl) ? (rep << shamt) : 64'd0;

    case (ctrl)
      MEM_LB:  load_val = {{56{shifted[7]}},  shifted[7:0]};
      MEM_LH:  load_val = {{48{shifted[15]}}, shifted[15:0]};
      MEM_LW:  load_val = {{32{shifted[31]}}, shifted[31:0]};
      MEM_LD:  load_val = shifted;
      MEM_LBU: load_val = {56'd0, shifted[7:0]};
      MEM_LHU: load_val = {48'd0, shifted[15:0]};
      MEM_LWU: load_val = {32'd0, shifted[31:0]};
      default: load_val = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_041461_mem.sv
// MEM pipeline stage of the ysyx_041461 core: one-entry holding stage that turns
// loads/stores into a request/response transaction on the data-memory port.
module ysyx_041461_mem
  import ysyx_041461_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_valid_in,
  input  logic [63:0]              MEM_exe_out,
  input  logic [63:0]              MEM_rs2_data,
  input  logic [3:0]               MEM_ctrl,
  input  logic [3:0]               MEM_trap_in,
  output logic                     MEM_ready,
  output logic [3:0]               MEM_trap,
  ysyx_041461_mem_if.master        dmem,
  output logic [63:0]              MEM_out,
  output logic                     MEM_valid_out,
  output logic [3:0]               MEM_trap_out,
  input  logic                     MEM_WB_ready
);

  mem_state_e  state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] rs2_q, rs2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [3:0]  trap_q, trap_d;
  logic [63:0] out_q, out_d;

  logic        accept, in_flight, req_active;
  logic [3:0]  al_ctrl;
  logic [2:0]  al_off;
  logic [63:0] al_rs2;
  logic        al_misalign;
  logic [7:0]  al_wmask;
  logic [63:0] al_wdata, al_load;

  // One alignment unit serves both the incoming entry (misalign check at accept)
  // and the latched entry while a transaction is in flight.
  assign in_flight = (state_q == S_REQ) || (state_q == S_WAIT);
  assign al_ctrl   = in_flight ? ctrl_q      : MEM_ctrl;
  assign al_off    = in_flight ? addr_q[2:0] : MEM_exe_out[2:0];
  assign al_rs2    = in_flight ? rs2_q       : MEM_rs2_data;

  ysyx_041461_mem_align u_align (
    .ctrl     (al_ctrl),
    .off      (al_off),
    .rs2      (al_rs2),
    .rdata    (dmem.MEM_resp_rdata),
    .misalign (al_misalign),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .load_val (al_load)
  );

  assign MEM_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && MEM_WB_ready);
  assign accept    = MEM_valid_in && MEM_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    ctrl_d  = ctrl_q;
    trap_d  = trap_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && MEM_WB_ready) begin
          state_d = S_IDLE;
          trap_d  = TRAP_NOP;
        end
        if (accept) begin
          addr_d = MEM_exe_out;
          rs2_d  = MEM_rs2_data;
          ctrl_d = MEM_ctrl;
          trap_d = MEM_trap_in;
          out_d  = 64'd0;
          if (MEM_trap_in != TRAP_NOP) begin
            state_d = S_HOLD;
          end else if (!(is_load(MEM_ctrl) || is_store(MEM_ctrl))) begin
            out_d   = MEM_exe_out;
            state_d = S_HOLD;
          end else if (al_misalign) begin
            trap_d  = is_store(MEM_ctrl) ? TRAP_STORE_MISALIGN : TRAP_LOAD_MISALIGN;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: if (dmem.MEM_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (dmem.MEM_resp_valid) begin
          out_d   = al_load;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      rs2_q   <= 64'd0;
      ctrl_q  <= MEM_NOP;
      trap_q  <= TRAP_NOP;
      out_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rs2_q   <= rs2_d;
      ctrl_q  <= ctrl_d;
      trap_q  <= trap_d;
      out_q   <= out_d;
    end
  end

  // Request fields are forced to zero outside REQ so the idle port is quiet.
  assign req_active         = (state_q == S_REQ);
  assign dmem.MEM_req_valid = req_active;
  assign dmem.MEM_req_addr  = req_active ? {addr_q[63:3], 3'b000} : 64'd0;
  assign dmem.MEM_req_wen   = req_active && is_store(ctrl_q);
  assign dmem.MEM_req_wmask = req_active ? al_wmask : 8'h00;
  assign dmem.MEM_req_wdata = req_active ? al_wdata : 64'd0;

  assign MEM_out       = out_q;
  assign MEM_valid_out = (state_q == S_HOLD);
  assign MEM_trap      = trap_q;
  assign MEM_trap_out  = trap_q;

endmodule
